// File: rtl/temp_sample_scheduler_pkg.sv
// Shared types and defaults for the round-robin temperature sample scheduler.
package temp_sample_scheduler_pkg;

  localparam int unsigned TEMP_W            = 8;
  localparam int unsigned RAW_W             = 4;
  localparam int unsigned BASE_W            = 5;
  localparam int unsigned COEF_W            = 4;
  localparam int unsigned DEF_SAMPLE_PERIOD = 1000;
  localparam int unsigned DEF_ACK_TIMEOUT   = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CALC    = 3'd3,
    ST_PUBLISH = 3'd4,
    ST_NEXT    = 3'd5
  } schedState_t;

endpackage

// File: rtl/temp_sample_scheduler_period_tick_gen.sv
// Free-running 0..PERIOD-1 counter; tick is high while the count sits at PERIOD-1.
module temp_sample_scheduler_period_tick_gen
  import temp_sample_scheduler_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;

  always_comb begin
    countNext = (count == LAST) ? '0 : count + CNT_W'(1);
  end

  // tick is registered from the next count so it lines up with count == LAST
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= countNext;
      tick  <= (countNext == LAST);
    end
  end

endmodule

// File: rtl/temp_sample_scheduler.sv
// Polls sensors round-robin each period, time-shares an external calculator,
// publishes results and tracks per-channel alarm (with hysteresis) and timeout flags.
module temp_sample_scheduler
  import temp_sample_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SENSORS   = 4,
  parameter int unsigned CH_W          = 2,
  parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int unsigned ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            enable,
  output logic [NUM_SENSORS-1:0]          sensorReq,
  input  logic [NUM_SENSORS-1:0]          sensorAck,
  input  logic [RAW_W*NUM_SENSORS-1:0]    sensorData,
  input  logic [BASE_W*NUM_SENSORS-1:0]   cfgBaseTemp,
  input  logic [COEF_W*NUM_SENSORS-1:0]   cfgTempCoef,
  input  logic [TEMP_W-1:0]               thrHigh,
  input  logic [TEMP_W-1:0]               thrLow,
  output logic [BASE_W-1:0]               calcBase,
  output logic [RAW_W-1:0]                calcSensor,
  output logic [COEF_W-1:0]               calcCoef,
  input  logic [TEMP_W-1:0]               calcTemp,
  output logic [TEMP_W-1:0]               tempOut,
  output logic [CH_W-1:0]                 tempChan,
  output logic                            tempValid,
  output logic [NUM_SENSORS-1:0]          alarm,
  output logic [NUM_SENSORS-1:0]          timeoutErr,
  output logic                            busy
);

  localparam int unsigned WAIT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  schedState_t state, stateNext;
  logic [CH_W-1:0]        ch, chNext;
  logic [WAIT_W-1:0]      waitCnt, waitCntNext;
  logic [NUM_SENSORS-1:0] sensorReqNext, alarmNext, timeoutErrNext;
  logic [BASE_W-1:0]      calcBaseNext;
  logic [RAW_W-1:0]       calcSensorNext;
  logic [COEF_W-1:0]      calcCoefNext;
  logic [TEMP_W-1:0]      tempOutNext;
  logic [CH_W-1:0]        tempChanNext;
  logic                   tempValidNext, busyNext;
  logic                   periodTick;

  logic [RAW_W-1:0]  rawArr  [NUM_SENSORS];
  logic [BASE_W-1:0] baseArr [NUM_SENSORS];
  logic [COEF_W-1:0] coefArr [NUM_SENSORS];

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_unpack
    assign rawArr[g]  = sensorData[g*RAW_W +: RAW_W];
    assign baseArr[g] = cfgBaseTemp[g*BASE_W +: BASE_W];
    assign coefArr[g] = cfgTempCoef[g*COEF_W +: COEF_W];
  end

  temp_sample_scheduler_period_tick_gen #(
    .PERIOD (SAMPLE_PERIOD)
  ) uTick (
    .clk  (clk),
    .rstn (rstn),
    .tick (periodTick)
  );

  // Sweep sequencing; registered outputs are computed from the next state
  always_comb begin
    stateNext      = state;
    chNext         = ch;
    waitCntNext    = waitCnt;
    calcBaseNext   = calcBase;
    calcSensorNext = calcSensor;
    calcCoefNext   = calcCoef;
    tempOutNext    = tempOut;
    tempChanNext   = tempChan;
    tempValidNext  = 1'b0;
    alarmNext      = alarm;
    timeoutErrNext = timeoutErr;

    case (state)
      ST_IDLE: begin
        if (periodTick && enable) begin
          chNext    = '0;
          stateNext = ST_REQ;
        end
      end
      ST_REQ: begin
        waitCntNext = '0;
        stateNext   = ST_WAIT;
      end
      ST_WAIT: begin
        if (sensorAck[ch]) begin
          calcSensorNext = rawArr[ch];
          calcBaseNext   = baseArr[ch];
          calcCoefNext   = coefArr[ch];
          stateNext      = ST_CALC;
        end else if (waitCnt == WAIT_W'(ACK_TIMEOUT)) begin
          timeoutErrNext[ch] = 1'b1;
          stateNext          = ST_NEXT;
        end else begin
          waitCntNext = waitCnt + WAIT_W'(1);
        end
      end
      ST_CALC: begin
        tempOutNext   = calcTemp;
        tempChanNext  = ch;
        tempValidNext = 1'b1;
        stateNext     = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        if (tempOut >= thrHigh) begin
          alarmNext[ch] = 1'b1;
        end else if (tempOut < thrLow) begin
          alarmNext[ch] = 1'b0;
        end
        stateNext = ST_NEXT;
      end
      ST_NEXT: begin
        if (ch == CH_W'(NUM_SENSORS - 1)) begin
          stateNext = ST_IDLE;
        end else begin
          chNext    = ch + CH_W'(1);
          stateNext = ST_REQ;
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase

    sensorReqNext = ((stateNext == ST_REQ) || (stateNext == ST_WAIT))
                    ? (NUM_SENSORS'(1) << chNext) : '0;
    busyNext      = (stateNext != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      ch         <= '0;
      waitCnt    <= '0;
      sensorReq  <= '0;
      calcBase   <= '0;
      calcSensor <= '0;
      calcCoef   <= '0;
      tempOut    <= '0;
      tempChan   <= '0;
      tempValid  <= 1'b0;
      alarm      <= '0;
      timeoutErr <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= stateNext;
      ch         <= chNext;
      waitCnt    <= waitCntNext;
      sensorReq  <= sensorReqNext;
      calcBase   <= calcBaseNext;
      calcSensor <= calcSensorNext;
      calcCoef   <= calcCoefNext;
      tempOut    <= tempOutNext;
      tempChan   <= tempChanNext;
      tempValid  <= tempValidNext;
      alarm      <= alarmNext;
      timeoutErr <= timeoutErrNext;
      busy       <= busyNext;
    end
  end

endmodule
